branch_resolver: RTL and testbench

- Execute-stage end of the branch-prediction interface.
- Takes each resolved control-flow instruction, compares the actual outcome with the prediction made at fetch, and on mismatch issues a registered redirect plus a timed pipeline flush.
- Trains a table of 2-bit saturating counters (PHT) and exposes a combinational lookup port, so fetch-side prediction can move from static to dynamic.

---
 rtl/branch_resolver_pkg.sv | 18 +
 rtl/branch_resolver_if.sv | 35 +++
 rtl/branch_resolver_pht.sv | 49 ++++
 rtl/branch_resolver.sv | 123 ++++++++++++
 tb/tb_branch_resolver.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver and its pattern history table.
package branch_pkg;

    typedef logic [1:0] pht_counter_t;

    localparam pht_counter_t STRONG_NT = 2'd0;
    localparam pht_counter_t WEAK_NT   = 2'd1;
    localparam pht_counter_t WEAK_T    = 2'd2;
    localparam pht_counter_t STRONG_T  = 2'd3;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } resolver_state_t;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/branch_resolver_if.sv
// Execute-to-resolver bus: resolved instruction handshake, PHT lookup and redirect/flush.
interface branch_resolver_if
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic             res_valid;
    logic             res_ready;
    logic [XLEN-1:0]  res_pc;
    logic [XLEN-1:0]  res_target;
    logic             res_jump;
    logic             res_branch;
    logic             res_cond;
    logic             res_predicted_taken;
    logic [XLEN-1:0]  lookup_pc;
    pht_counter_t     lookup_counter;
    logic             lookup_taken;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;

    modport master (
        output res_valid, res_pc, res_target, res_jump, res_branch, res_cond,
               res_predicted_taken, lookup_pc,
        input  res_ready, lookup_counter, lookup_taken, redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  res_valid, res_pc, res_target, res_jump, res_branch, res_cond,
               res_predicted_taken, lookup_pc,
        output res_ready, lookup_counter, lookup_taken, redirect_valid, redirect_pc, flush
    );

endinterface

// File: rtl/branch_resolver_pht.sv
// Pattern history table of 2-bit saturating counters with a combinational lookup port.
module branch_pht
    import branch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            update_en,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] lookup_pc,
    output pht_counter_t    lookup_counter
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    pht_counter_t            counters_q [ENTRIES];
    logic [INDEX_BITS-1:0]   update_idx;
    logic [INDEX_BITS-1:0]   lookup_idx;
    logic                    unused_pc_bits;

    function automatic pht_counter_t sat_update(input pht_counter_t c, input logic taken);
        if (taken)
            return (c == STRONG_T) ? c : pht_counter_t'(c + 2'd1);
        else
            return (c == STRONG_NT) ? c : pht_counter_t'(c - 2'd1);
    endfunction

    assign update_idx = update_pc[INDEX_BITS+1:2];
    assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{update_pc[XLEN-1:INDEX_BITS+2], update_pc[1:0],
                              lookup_pc[XLEN-1:INDEX_BITS+2], lookup_pc[1:0]};

    // Read returns the stored value, so a same-cycle update is not visible until the next cycle.
    assign lookup_counter = counters_q[lookup_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counters_q[i] <= WEAK_NT;
            end
        end else if (update_en) begin
            counters_q[update_idx] <= sat_update(counters_q[update_idx], update_taken);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: detects mispredicts, issues a registered redirect plus timed flush, trains the PHT.
// Optional BRANCH_PERF_COUNTERS_EN adds branch_count / mispredict_count outputs.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int PHT_INDEX_BITS = 6,
    parameter int FLUSH_CYCLES   = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    branch_resolver_if.slave   bus
`ifdef BRANCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]        branch_count,
    output logic [31:0]        mispredict_count
`endif
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    resolver_state_t   state_q, state_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              ready;
    logic              flush;
    logic              accept;
    logic              is_cf;
    logic              actual_taken;
    logic              mispredict;
    logic              train;
    logic [XLEN-1:0]   correct_pc;
    logic              redirect_valid_p1;
    logic [XLEN-1:0]   redirect_pc_p1;

    assign accept       = bus.res_valid && ready;
    assign is_cf        = bus.res_jump || bus.res_branch;
    assign actual_taken = bus.res_jump || (bus.res_branch && bus.res_cond);
    assign mispredict   = is_cf && (actual_taken != bus.res_predicted_taken);
    assign correct_pc   = actual_taken ? bus.res_target
                                       : bus.res_pc + XLEN'(INSTR_BYTES);
    // A jump flagged as a branch is still a jump and must not train the table.
    assign train        = accept && bus.res_branch && !bus.res_jump;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        ready       = 1'b0;
        flush       = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (accept && mispredict) begin
                    state_d     = FLUSH;
                    flush_cnt_d = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (flush_cnt_q == '0)
                    state_d = IDLE;
                else
                    flush_cnt_d = flush_cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: redirect registered one cycle after the accepting edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            redirect_valid_p1 <= 1'b0;
            redirect_pc_p1    <= '0;
        end else begin
            redirect_valid_p1 <= accept && mispredict;
            if (accept && mispredict)
                redirect_pc_p1 <= correct_pc;
        end
    end

    branch_pht #(
        .XLEN       (XLEN),
        .INDEX_BITS (PHT_INDEX_BITS)
    ) u_pht (
        .clk            (clk),
        .reset_n        (reset_n),
        .update_en      (train),
        .update_pc      (bus.res_pc),
        .update_taken   (bus.res_cond),
        .lookup_pc      (bus.lookup_pc),
        .lookup_counter (bus.lookup_counter)
    );

    assign bus.lookup_taken   = bus.lookup_counter[1];
    assign bus.res_ready      = ready;
    assign bus.flush          = flush;
    assign bus.redirect_valid = redirect_valid_p1;
    assign bus.redirect_pc    = redirect_pc_p1;

`ifdef BRANCH_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (accept) begin
            if (is_cf)
                branch_count <= branch_count + 32'd1;
            if (mispredict)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: redirect/flush timing, PHT training, wrap and reset abort.
module tb_branch_resolver;
    import branch_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    branch_resolver_if #(.XLEN(32)) bus ();

`ifdef BRANCH_PERF_COUNTERS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    branch_resolver #(
        .XLEN           (32),
        .PHT_INDEX_BITS (6),
        .FLUSH_CYCLES   (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef BRANCH_PERF_COUNTERS_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called at a negedge; presents one instruction for one accepting edge, returns at the next negedge.
    task automatic present(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic j, input logic b, input logic c, input logic p);
        bus.res_pc              = pc;
        bus.res_target          = tgt;
        bus.res_jump            = j;
        bus.res_branch          = b;
        bus.res_cond            = c;
        bus.res_predicted_taken = p;
        bus.res_valid           = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.res_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", 32'(bus.res_ready), 32'd1);
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic [1:0] exp);
        bus.lookup_pc = pc;
        #1;
        check(tag, 32'(bus.lookup_counter), 32'(exp));
    endtask

    initial begin
        reset_n                 = 1'b0;
        bus.res_valid           = 1'b0;
        bus.res_pc              = '0;
        bus.res_target          = '0;
        bus.res_jump            = 1'b0;
        bus.res_branch          = 1'b0;
        bus.res_cond            = 1'b0;
        bus.res_predicted_taken = 1'b0;
        bus.lookup_pc           = '0;
        repeat (2) @(negedge clk);

        check("rst_ready",    32'(bus.res_ready), 32'd1);
        check("rst_rvalid",   32'(bus.redirect_valid), 32'd0);
        check("rst_rpc",      bus.redirect_pc, 32'd0);
        check("rst_flush",    32'(bus.flush), 32'd0);
        lookup("rst_pht",     32'h100, 2'b01);
        reset_n = 1'b1;
        @(negedge clk);

        // Correctly predicted taken branch: no redirect, index 0 trains 01 -> 10
        present(32'h100, 32'h80, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t1_rvalid", 32'(bus.redirect_valid), 32'd0);
        check("t1_flush",  32'(bus.flush), 32'd0);
        check("t1_ready",  32'(bus.res_ready), 32'd1);
        lookup("t1_pht",   32'h100, 2'b10);

        // Predicted taken, actually not taken: redirect to pc+4, two flush cycles
        present(32'h200, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t2_rvalid_c1", 32'(bus.redirect_valid), 32'd1);
        check("t2_rpc_c1",    bus.redirect_pc, 32'h204);
        check("t2_flush_c1",  32'(bus.flush), 32'd1);
        check("t2_ready_c1",  32'(bus.res_ready), 32'd0);
        @(negedge clk);
        check("t2_rvalid_c2", 32'(bus.redirect_valid), 32'd0);
        check("t2_rpc_hold",  bus.redirect_pc, 32'h204);
        check("t2_flush_c2",  32'(bus.flush), 32'd1);
        check("t2_ready_c2",  32'(bus.res_ready), 32'd0);
        @(negedge clk);
        check("t2_flush_c3",  32'(bus.flush), 32'd0);
        check("t2_ready_c3",  32'(bus.res_ready), 32'd1);
        lookup("t2_pht",      32'h200, 2'b01);

        // Jump (also flagged branch, cond=0): jump wins, target taken, no training
        present(32'h400, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_rvalid", 32'(bus.redirect_valid), 32'd1);
        check("t3_rpc",    bus.redirect_pc, 32'h40);
        lookup("t3_pht",   32'h0, 2'b01);
        wait_ready();

        // Back-to-back correct predictions at pc 0x10 (index 4)
        present(32'h10, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1);
        lookup("t4_cnt1", 32'h10, 2'b10);
        present(32'h10, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1);
        lookup("t4_cnt2", 32'h10, 2'b11);
        present(32'h10, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1);
        lookup("t4_cnt3", 32'h10, 2'b11);
        present(32'h10, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1);
        lookup("t4_cnt4", 32'h10, 2'b11);
        check("t4_ready", 32'(bus.res_ready), 32'd1);
        present(32'h10, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        lookup("t4_cnt5", 32'h10, 2'b10);
        check("t4_taken",  32'(bus.lookup_taken), 32'd1);
        check("t4_rvalid", 32'(bus.redirect_valid), 32'd0);

        // Neither jump nor branch: discarded, nothing changes
        present(32'h10, 32'h20, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_rvalid", 32'(bus.redirect_valid), 32'd0);
        check("t5_flush",  32'(bus.flush), 32'd0);
        lookup("t5_pht",   32'h10, 2'b10);

        // pc+4 wraps to zero
        present(32'hFFFF_FFFC, 32'h1234, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t6_rvalid", 32'(bus.redirect_valid), 32'd1);
        check("t6_rpc",    bus.redirect_pc, 32'h0);
        lookup("t6_pht",   32'hFFFF_FFFC, 2'b00);
        wait_ready();

        // Same-cycle lookup and update on index 4 returns the pre-update value
        bus.lookup_pc           = 32'h10;
        bus.res_pc              = 32'h10;
        bus.res_target          = 32'h20;
        bus.res_jump            = 1'b0;
        bus.res_branch          = 1'b1;
        bus.res_cond            = 1'b1;
        bus.res_predicted_taken = 1'b1;
        bus.res_valid           = 1'b1;
        #1;
        check("t7_pre",  32'(bus.lookup_counter), 32'd2);
        @(posedge clk);
        @(negedge clk);
        bus.res_valid = 1'b0;
        check("t7_post", 32'(bus.lookup_counter), 32'd3);

        // Reset on the first flush cycle aborts the flush and reinitialises the PHT
        present(32'h10, 32'h20, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t8_flush_pre", 32'(bus.flush), 32'd1);
        lookup("t8_pht_pre",  32'h10, 2'b10);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t8_flush",  32'(bus.flush), 32'd0);
        check("t8_rvalid", 32'(bus.redirect_valid), 32'd0);
        check("t8_ready",  32'(bus.res_ready), 32'd1);
        for (int i = 0; i < 64; i++) begin
            lookup($sformatf("t8_pht_%0d", i), 32'(i) << 2, 2'b01);
        end
        reset_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
